// File: rtl/chrono_ctrl.sv
// Run-control sequencer for the stopwatch digit chain: button edges, preset load, tick prescaler, done/blink.
// Optional feature macro: CHRONO_DONE_TIMEOUT_EN (automatic DONE -> IDLE after DONE_TICKS prescaler wraps).
module chrono_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int DONE_TICKS = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_CLEAR,
    input  logic [5:0] SEL,
    input  logic       ZERO,
    output logic       LOAD,
    output logic [2:0] PRESET,
    output logic       CLR,
    output logic       TICK,
    output logic       RUNNING,
    output logic       DONE,
    output logic       BLINK,
    output logic       SEL_ERR
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [2:0]    preset_q, preset_d;
    logic          blink_q, blink_d;
    logic          start_q, clear_q;

    logic          clr_edge, start_edge;
    logic          sel_onehot;
    logic [2:0]    sel_enc;
    logic          ps_wrap;
    logic [PW-1:0] ps_inc;
    logic          timeout;
    logic          load, clr, tick, sel_err;

    // A simultaneous clear edge swallows the start edge.
    assign clr_edge   = BTN_CLEAR & ~clear_q;
    assign start_edge = BTN_START & ~start_q & ~clr_edge;

    assign sel_onehot = (SEL != 6'd0) && ((SEL & (SEL - 6'd1)) == 6'd0);

    always_comb begin
        sel_enc = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (SEL[i]) sel_enc = 3'(i);
        end
    end

    assign ps_wrap = (ps_q == PS_MAX);
    assign ps_inc  = ps_wrap ? '0 : ps_q + PW'(1);

`ifdef CHRONO_DONE_TIMEOUT_EN
    localparam int WW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS + 1) : 1;

    logic [WW-1:0] wraps_q, wraps_d;

    // Wrap counter only advances inside DONE; it is already zero on entry.
    assign wraps_d = (state_q != S_DONE) ? '0 : (ps_wrap ? wraps_q + WW'(1) : wraps_q);
    assign timeout = (state_q == S_DONE) && ps_wrap && (wraps_q == WW'(DONE_TICKS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            wraps_q <= '0;
        end else begin
            wraps_q <= wraps_d;
        end
    end
`else
    assign timeout = 1'b0 & (DONE_TICKS != 0);
`endif

    always_comb begin
        state_d  = state_q;
        ps_d     = ps_q;
        preset_d = preset_q;
        blink_d  = blink_q;
        load     = 1'b0;
        clr      = 1'b0;
        tick     = 1'b0;
        sel_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_edge) begin
                    clr = 1'b1;
                end else if (start_edge) begin
                    if (sel_onehot) begin
                        load     = 1'b1;
                        preset_d = sel_enc;
                        ps_d     = '0;
                        state_d  = S_RUN;
                    end else begin
                        sel_err = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // The pausing cycle still counts as a RUN cycle, so pause/resume stays exact.
                ps_d = ps_inc;
                tick = ps_wrap & ~ZERO;
                if (clr_edge) begin
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end else if (ZERO) begin
                    blink_d = 1'b0;
                    state_d = S_DONE;
                end else if (start_edge) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (clr_edge) begin
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end else if (start_edge) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                ps_d = ps_inc;
                if (ps_wrap) blink_d = ~blink_q;
                if (clr_edge || start_edge || timeout) begin
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            ps_q     <= '0;
            preset_q <= 3'd0;
            blink_q  <= 1'b0;
            start_q  <= 1'b1;
            clear_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            preset_q <= preset_d;
            blink_q  <= blink_d;
            start_q  <= BTN_START;
            clear_q  <= BTN_CLEAR;
        end
    end

    // Strobes are masked while RST is high so reset itself never loads or clears the chain.
    assign LOAD    = load & ~RST;
    assign CLR     = clr & ~RST;
    assign TICK    = tick & ~RST;
    assign SEL_ERR = sel_err & ~RST;
    assign PRESET  = LOAD ? sel_enc : preset_q;
    assign RUNNING = (state_q == S_RUN);
    assign DONE    = (state_q == S_DONE);
    assign BLINK   = (state_q == S_DONE) & blink_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Scoreboard bench for chrono_ctrl with TICK_DIV=4, DONE_TICKS=3.
// Expectations follow CHRONO_DONE_TIMEOUT_EN the same way the design does.
module tb_chrono_ctrl;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam logic [5:0] SM  = 6'b001000;
    localparam logic [5:0] SL  = 6'b000100;
    localparam logic [5:0] SA  = 6'b000010;
    localparam logic [5:0] SP  = 6'b100000;
    localparam logic [5:0] S00 = 6'b000000;
    localparam logic [5:0] S2B = 6'b100100;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_START = 1'b0;
    logic       BTN_CLEAR = 1'b0;
    logic       ZERO = 1'b0;
    logic [5:0] SEL = 6'b001000;
    logic       LOAD, CLR, TICK, RUNNING, DONE, BLINK, SEL_ERR;
    logic [2:0] PRESET;

    chrono_ctrl #(.TICK_DIV(TD), .DONE_TICKS(DT)) dut (
        .CLK(CLK), .RST(RST), .BTN_START(BTN_START), .BTN_CLEAR(BTN_CLEAR),
        .SEL(SEL), .ZERO(ZERO), .LOAD(LOAD), .PRESET(PRESET), .CLR(CLR),
        .TICK(TICK), .RUNNING(RUNNING), .DONE(DONE), .BLINK(BLINK), .SEL_ERR(SEL_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, st, cl, z;
        logic [5:0] sel;
        logic       chk;
        logic [9:0] exp;
    } cyc_t;

    cyc_t       st_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         n_run  = 0;
    int         n_fail = 0;

    // Vector layout: {LOAD, PRESET[2:0], CLR, TICK, RUNNING, DONE, BLINK, SEL_ERR}
    function automatic logic [9:0] o(input logic ld, input logic [2:0] pr, input logic cl,
                                     input logic tk, input logic rn, input logic dn,
                                     input logic bl, input logic er);
        return {ld, pr, cl, tk, rn, dn, bl, er};
    endfunction

    task automatic add(input logic rst, input logic st, input logic cl, input logic z,
                       input logic [5:0] sel, input logic chk, input logic [9:0] e);
        cyc_t c;
        c.rst = rst; c.st = st; c.cl = cl; c.z = z; c.sel = sel; c.chk = chk; c.exp = e;
        st_q.push_back(c);
    endtask

    // Drives one queued cycle per clock; expected value queued on drive, DUT value captured mid-cycle.
    task automatic play();
        cyc_t c;
        while (st_q.size() > 0) begin
            c = st_q.pop_front();
            RST = c.rst; BTN_START = c.st; BTN_CLEAR = c.cl; ZERO = c.z; SEL = c.sel;
            if (c.chk) exp_q.push_back(c.exp);
            @(negedge CLK);
            if (c.chk) got_q.push_back({LOAD, PRESET, CLR, TICK, RUNNING, DONE, BLINK, SEL_ERR});
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [9:0] e, g;
        add(1, 0, 0, 0, SM, 0, 10'd0);
        add(1, 0, 0, 0, SM, 0, 10'd0);
        add(0, 0, 0, 0, SM, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SM, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        play();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL reset[%0d] got %b want %b", i, g, e); end
        end
    endtask

    task automatic test_start();
        logic [9:0] e, g;
        add(0, 1, 0, 0, SM, 1, o(1, 3, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            add(0, k == 1, 0, 0, (k >= 3) ? SP : SM, 1, o(0, 3, 0, (k % 4) == 0, 1, 0, 0, 0));
        add(0, 0, 1, 0, SP, 1, o(0, 3, 1, 0, 1, 0, 0, 0));
        add(0, 0, 0, 0, SP, 1, o(0, 3, 0, 0, 0, 0, 0, 0));
        play();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL start[%0d] got %b want %b", i, g, e); end
        end
    endtask

    task automatic test_sel_err();
        logic [9:0] e, g;
        add(0, 1, 0, 0, S00, 1, o(0, 3, 0, 0, 0, 0, 0, 1));
        add(0, 1, 0, 0, S00, 1, o(0, 3, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, S00, 1, o(0, 3, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, S2B, 1, o(0, 3, 0, 0, 0, 0, 0, 1));
        add(0, 0, 0, 0, S2B, 1, o(0, 3, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SM,  1, o(0, 3, 0, 0, 0, 0, 0, 0));
        play();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL sel_err[%0d] got %b want %b", i, g, e); end
        end
    endtask

    task automatic test_pause();
        logic [9:0] e, g;
        add(0, 1, 0, 0, SL, 1, o(1, 2, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 1, 0, 0, 0));
        add(0, 1, 0, 0, SL, 1, o(0, 2, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < 10; k++) add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, SL, 1, o(0, 2, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 1, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 1, 1, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 1, 0, 0, 0));
        add(0, 0, 1, 0, SL, 1, o(0, 2, 1, 0, 1, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 0, 0, 0, 0));
        play();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL pause[%0d] got %b want %b", i, g, e); end
        end
    endtask

    task automatic test_done();
        logic [9:0] e, g;
        add(0, 1, 0, 0, SA, 1, o(1, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, SA, 1, o(0, 1, 0, 0, 1, 0, 0, 0));
        // ZERO and a start edge together at prescaler 3: ZERO wins, no TICK.
        add(0, 1, 0, 1, SA, 1, o(0, 1, 0, 0, 1, 0, 0, 0));
`ifdef CHRONO_DONE_TIMEOUT_EN
        for (int k = 0; k < 12; k++)
            add(0, 0, 0, 0, SA, 1, o(0, 1, k == 11, 0, 0, 1, 1'((k / 4) % 2), 0));
        add(0, 0, 0, 0, SA, 1, o(0, 1, 0, 0, 0, 0, 0, 0));
`else
        for (int k = 0; k < 100; k++)
            add(0, 0, 0, 0, SA, 1, o(0, 1, 0, 0, 0, 1, 1'((k / 4) % 2), 0));
        add(0, 1, 0, 0, SA, 1, o(0, 1, 1, 0, 0, 1, 1, 0));
        add(0, 0, 0, 0, SA, 1, o(0, 1, 0, 0, 0, 0, 0, 0));
`endif
        play();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL done[%0d] got %b want %b", i, g, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e, g;
        add(0, 1, 0, 0, SM, 1, o(1, 3, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SM, 1, o(0, 3, 0, 0, 1, 0, 0, 0));
        add(0, 1, 1, 0, SM, 1, o(0, 3, 1, 0, 1, 0, 0, 0));
        add(0, 1, 1, 0, SM, 1, o(0, 3, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SM, 1, o(0, 3, 0, 0, 0, 0, 0, 0));
        // Start held high across reset: no LOAD during or after it.
        add(1, 1, 0, 0, SM, 1, o(0, 3, 0, 0, 0, 0, 0, 0));
        add(1, 1, 0, 0, SM, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, SM, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, SM, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SM, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 0, 1, 0, SM, 1, o(0, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SM, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        play();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL back_to_back[%0d] got %b want %b", i, g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e, g;
        add(0, 1, 0, 0, SL, 1, o(1, 2, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 1, 0, 0, 0));
        add(0, 1, 0, 0, SL, 1, o(0, 2, 0, 0, 1, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 0, 0, 0, 0));
        add(1, 0, 0, 0, SL, 1, o(0, 2, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SL, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, SP, 1, o(1, 5, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 1, SP, 1, o(0, 5, 0, 0, 1, 0, 0, 0));
        add(0, 0, 0, 1, SP, 1, o(0, 5, 0, 0, 0, 1, 0, 0));
        add(1, 0, 0, 0, SP, 1, o(0, 5, 0, 0, 0, 1, 0, 0));
        add(0, 0, 0, 0, SP, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0, SM, 1, o(1, 3, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, SM, 1, o(0, 3, 0, 0, 1, 0, 0, 0));
        play();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++;
            if (g !== e) begin n_fail++; $display("FAIL reset_mid[%0d] got %b want %b", i, g, e); end
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset();
        test_start();
        test_sel_err();
        test_pause();
        test_done();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
